// File: rtl/div_pkg.sv
// Shared types and constants for the shift-divider controller and its datapath step.
package div_pkg;

  // Controller states; values are fixed so they can be matched in waveforms and checkers.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Default operand width of the divider.
  localparam int DIV_WIDTH = 16;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {P,Q} left by one, then conditionally subtract the divisor.
// Between iterations P is always below the divisor, so it is carried as WIDTH bits.
// Only the shifted value needs the extra bit, and that bit takes part in the compare.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] p_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] p_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] p_sh;
  logic           ge;

  // Shift, compare against the zero-extended divisor, restore-or-subtract, and insert the quotient bit.
  always_comb begin
    p_sh = {p_i, q_i[WIDTH-1]};
    ge   = (p_sh >= {1'b0, divisor_i});
    // The difference is below the divisor, so the low WIDTH bits hold the exact result.
    p_o  = ge ? (p_sh[WIDTH-1:0] - divisor_i) : p_sh[WIDTH-1:0];
    q_o  = {q_i[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/shift_div_ctrl.sv
// Iterative restoring divider controller.
// It accepts operands on start, runs WIDTH shift/subtract steps,
// and then presents the registered quotient and remainder together with a one-cycle done pulse.
//
// Handshake:
// - start is sampled only in IDLE.
// - busy is high exactly while the iterations run.
// - done is high for the single DONE cycle, and the results are valid from that cycle on.
// - Results hold until the next done.
// - abort cancels a run without touching the results.
module shift_div_ctrl
  import div_pkg::*;
#(
  parameter  int WIDTH = DIV_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output state_t           dbg_state
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] p_step, q_step;

  div_step #(.WIDTH(WIDTH)) u_step (
    .p_i       (p_q),
    .q_i       (q_q),
    .divisor_i (dvs_q),
    .p_o       (p_step),
    .q_o       (q_step)
  );

  // Next-state logic: FSM transitions, operand capture, iteration update, and result load on entry to DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            dvs_d   = divisor;
            p_d     = '0;
            q_d     = dividend;
            cnt_d   = '0;
            state_d = ST_RUN;
          end else begin
            // Divide-by-zero: report immediately with all-ones quotient and the dividend as remainder.
            dbz_d   = 1'b1;
            quo_d   = '1;
            rem_d   = dividend;
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          p_d   = p_step;
          q_d   = q_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            quo_d   = q_step;
            rem_d   = p_step;
            dbz_d   = 1'b0;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_shift_div_ctrl.sv
// Directed testbench for shift_div_ctrl with hand-computed expected results.
module tb_shift_div_ctrl;
  import div_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;
  state_t       dbg_state;

  int   checks = 0;
  int   errors = 0;
  int   cyc, busy_cnt, done_cnt;
  logic done_seen;

  shift_div_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  // Clock and reset block
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: issue start in cycle 0, then watch up to 40 cycles for done.
  // Optionally re-pulse start with other operands at cycle inj_cyc,
  // and optionally hold abort high during the start cycle.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int inj_cyc, input logic abort_first);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b; abort = abort_first;
    cyc = 0; busy_cnt = 0; done_seen = 1'b0;
    while (!done_seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = 1'b0; abort = 1'b0;
      if (busy) busy_cnt++;
      if (done) done_seen = 1'b1;
      if (cyc == inj_cyc) begin
        start = 1'b1; dividend = 16'h1234; divisor = 16'h0003;
      end
    end
  endtask

  task automatic chk_result(input string tag, input logic [W-1:0] eq, input logic [W-1:0] er,
                            input logic edbz, input int elat, input int ebusy);
    chk({tag, "_done_seen"}, done_seen, 1'b1);
    chk({tag, "_latency"}, cyc, elat);
    chk({tag, "_busy_cycles"}, busy_cnt, ebusy);
    chk({tag, "_quotient"}, quotient, eq);
    chk({tag, "_remainder"}, remainder, er);
    chk({tag, "_dbz"}, div_by_zero, edbz);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_quotient", quotient, 16'h0);
    chk("rst_remainder", remainder, 16'h0);
    chk("rst_dbz", div_by_zero, 1'b0);
    rst_n = 1'b1;

    // 1. 100/7 = 14 r 2, done 17 cycles after start, busy 16 cycles
    run_div(16'd100, 16'd7, 0, 1'b0);
    chk_result("t1_100_7", 16'd14, 16'd2, 1'b0, 17, 16);
    @(negedge clk);
    chk("t1_done_one_cycle", done, 1'b0);

    // 2. Boundary operands
    run_div(16'hFFFF, 16'h0001, 0, 1'b0);
    chk_result("t2_ffff_1", 16'hFFFF, 16'h0000, 1'b0, 17, 16);
    run_div(16'hFFFF, 16'h8000, 0, 1'b0);
    chk_result("t2_ffff_8000", 16'h0001, 16'h7FFF, 1'b0, 17, 16);

    // 3. Divide by zero: done one cycle after start, never busy
    run_div(16'd5, 16'd0, 0, 1'b0);
    chk_result("t3_5_0", 16'hFFFF, 16'd5, 1'b1, 1, 0);
    @(negedge clk);
    chk("t3_done_one_cycle", done, 1'b0);

    // 4. Dividend smaller than divisor; start in DONE cycle ignored
    run_div(16'd3, 16'd10, 0, 1'b0);
    chk_result("t4_3_10", 16'd0, 16'd3, 1'b0, 17, 16);
    start = 1'b1; dividend = 16'd50; divisor = 16'd5;
    @(negedge clk);
    start = 1'b0;
    chk("t4_done_start_busy", busy, 1'b0);
    chk("t4_done_start_done", done, 1'b0);
    chk("t4_done_start_quotient", quotient, 16'd0);
    run_div(16'd50, 16'd5, 0, 1'b0);
    chk_result("t4_50_5", 16'd10, 16'd0, 1'b0, 17, 16);

    // 5. Start during busy ignored; abort mid-run keeps results
    run_div(16'd1000, 16'd3, 5, 1'b0);
    chk_result("t5_1000_3", 16'd333, 16'd1, 1'b0, 17, 16);
    @(negedge clk);
    start = 1'b1; dividend = 16'd60000; divisor = 16'd7;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 8) abort = 1'b1;
    end
    @(negedge clk);
    abort = 1'b0;
    chk("t5_abort_busy", busy, 1'b0);
    done_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("t5_abort_no_done", done_cnt, 0);
    chk("t5_abort_quotient", quotient, 16'd333);
    chk("t5_abort_remainder", remainder, 16'd1);
    chk("t5_abort_dbz", div_by_zero, 1'b0);

    // 6. Asynchronous reset in the middle of a run, then a fresh division
    //    (abort held during the accepted start has no effect in IDLE).
    @(negedge clk);
    start = 1'b1; dividend = 16'd1234; divisor = 16'd5;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_done", done, 1'b0);
    chk("t6_rst_quotient", quotient, 16'd0);
    chk("t6_rst_remainder", remainder, 16'd0);
    chk("t6_rst_dbz", div_by_zero, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_div(16'd200, 16'd9, 0, 1'b1);
    chk_result("t6_200_9", 16'd22, 16'd2, 1'b0, 17, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
